// File: rtl/mux_rr_arb.sv
// mux_rr_arb: CHANNELS-way valid/ready stream multiplexer with one registered
// output stage. mode=0 forwards the channel chosen by sel; mode=1 arbitrates
// round-robin starting after the last-granted channel (ptr).
// Optional packet locking: define MUX_RR_ARB_LAST_EN to add in_last/out_last.
// With it, a round-robin grant stays on one channel until its last beat.
module mux_rr_arb #(
  parameter int N        = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS*N-1:0] in_data,
  input  logic [CHANNELS-1:0]   in_valid,
  output logic [CHANNELS-1:0]   in_ready,
`ifdef MUX_RR_ARB_LAST_EN
  input  logic [CHANNELS-1:0]   in_last,
  output logic                  out_last,
`endif
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [N-1:0]          out_data,
  output logic [SEL_W-1:0]      out_chan,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [N-1:0]         out_data_q, out_data_d;
  logic [SEL_W-1:0]     out_chan_q, out_chan_d;
  logic                 out_valid_q, out_valid_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;

  logic [CHANNELS-1:0]  grant;
  logic                 rr_found;
  int unsigned          rr_idx;
  logic [N-1:0]         gnt_data;
  logic [SEL_W-1:0]     gnt_chan;
  logic                 load;
  logic                 xfer;

`ifdef MUX_RR_ARB_LAST_EN
  logic                 lock_q, lock_d;
  logic                 out_last_q, out_last_d;
  logic                 gnt_last;
`endif

  // Grant: fixed select compares sel against each valid channel index, so an
  // out-of-range sel simply matches nothing; round-robin scans ptr+1 onward
  // modulo CHANNELS (not 2^SEL_W) and keeps the first valid channel.
  always_comb begin
    grant    = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    if (!mode) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        grant[i] = in_valid[i] && (sel == SEL_W'(i));
      end
    end else begin
`ifdef MUX_RR_ARB_LAST_EN
      // Mid-packet: only the owning channel may continue.
      if (lock_q) begin
        grant[ptr_q] = in_valid[ptr_q];
        rr_found     = 1'b1;
      end
`endif
      for (int unsigned k = 1; k <= CHANNELS; k++) begin
        rr_idx = (32'(ptr_q) + k) % CHANNELS;
        if (!rr_found && in_valid[rr_idx]) begin
          grant[rr_idx] = 1'b1;
          rr_found      = 1'b1;
        end
      end
    end
  end

  // Encode the one-hot grant into data/index of the winning channel.
  always_comb begin
    gnt_data = '0;
    gnt_chan = '0;
`ifdef MUX_RR_ARB_LAST_EN
    gnt_last = 1'b0;
`endif
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        gnt_data = in_data[i*N +: N];
        gnt_chan = SEL_W'(i);
`ifdef MUX_RR_ARB_LAST_EN
        gnt_last = in_last[i];
`endif
      end
    end
  end

  // Handshake: the output slot accepts when empty or draining this cycle;
  // ready is forced low while reset is held.
  always_comb begin
    load     = !out_valid_q || out_ready;
    in_ready = (load && rst) ? grant : '0;
    xfer     = |in_ready;
  end

  // Next-state for the output stage, arbitration pointer and packet lock.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
`ifdef MUX_RR_ARB_LAST_EN
    out_last_d  = out_last_q;
    lock_d      = lock_q;
`endif
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = gnt_data;
        out_chan_d = gnt_chan;
`ifdef MUX_RR_ARB_LAST_EN
        out_last_d = gnt_last;
`endif
      end
    end
    if (xfer) begin
      ptr_d = gnt_chan;
    end
`ifdef MUX_RR_ARB_LAST_EN
    if (!mode) begin
      lock_d = 1'b0;
    end else if (xfer) begin
      lock_d = !gnt_last;
    end
`endif
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SEL_W'(CHANNELS - 1);
`ifdef MUX_RR_ARB_LAST_EN
      out_last_q  <= 1'b0;
      lock_q      <= 1'b0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
`ifdef MUX_RR_ARB_LAST_EN
      out_last_q  <= out_last_d;
      lock_q      <= lock_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
`ifdef MUX_RR_ARB_LAST_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed bench for mux_rr_arb: an 8-channel instance for the main checks and
// a 3-channel instance for non-power-of-two wrap and out-of-range sel.
module tb_mux_rr_arb;

  logic        clk;
  logic        rst;

  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  out_data;
  logic [2:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic [23:0] d3_in_data;
  logic [2:0]  d3_in_valid;
  logic [2:0]  d3_in_ready;
  logic        d3_mode;
  logic [1:0]  d3_sel;
  logic [7:0]  d3_out_data;
  logic [1:0]  d3_out_chan;
  logic        d3_out_valid;
  logic        d3_out_ready;

`ifdef MUX_RR_ARB_LAST_EN
  logic [7:0]  in_last;
  logic        out_last;
  logic [2:0]  d3_in_last;
  logic        d3_out_last;
`endif

  int n_assert;
  int n_fail;

  mux_rr_arb #(.N(8), .CHANNELS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef MUX_RR_ARB_LAST_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_rr_arb #(.N(8), .CHANNELS(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (d3_in_data),
    .in_valid  (d3_in_valid),
    .in_ready  (d3_in_ready),
`ifdef MUX_RR_ARB_LAST_EN
    .in_last   (d3_in_last),
    .out_last  (d3_out_last),
`endif
    .mode      (d3_mode),
    .sel       (d3_sel),
    .out_data  (d3_out_data),
    .out_chan  (d3_out_chan),
    .out_valid (d3_out_valid),
    .out_ready (d3_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] c);
    chk({tag, "_valid"}, 64'(out_valid), 64'(v));
    chk({tag, "_chan"},  64'(out_chan),  64'(c));
    chk({tag, "_data"},  64'(out_data),  64'(8'(c * 8'h11)));
  endtask

  initial begin
    int rr_seq[6];
    int d3_seq[4];
    n_assert = 0;
    n_fail   = 0;
    rr_seq   = '{0, 2, 5, 7, 0, 2};
    d3_seq   = '{0, 1, 2, 0};

    rst = 1'b0;
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(i * 8'h11);
    for (int i = 0; i < 3; i++) d3_in_data[i*8 +: 8] = 8'(8'hA0 + i);
    in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    d3_in_valid = '0; d3_mode = 1'b0; d3_sel = '0; d3_out_ready = 1'b0;
`ifdef MUX_RR_ARB_LAST_EN
    in_last = '1;
    d3_in_last = '1;
`endif

    // Held in reset: outputs zero, no ready even with a valid selected channel.
    tick(); tick();
    in_valid = 8'hFF; mode = 1'b0; sel = 3'd5; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_chan",  64'(out_chan),  64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    tick();
    chk("rst_hold_valid", 64'(out_valid), 64'd0);

    // Release: first round-robin grant goes to channel 0.
    rst = 1'b1; mode = 1'b1;
    #1;
    chk("rr_first_ready", 64'(in_ready), 64'h01);
    tick();
    chk_out("rr_first", 1'b1, 3'd0);

    // Fixed select sel=5.
    mode = 1'b0; sel = 3'd5;
    #1;
    chk("fix_ready", 64'(in_ready), 64'h20);
    tick();
    chk_out("fix_b0", 1'b1, 3'd5);
    chk("fix_ready_b1", 64'(in_ready), 64'h20);
    tick();
    chk_out("fix_b1", 1'b1, 3'd5);

    // Park ptr on channel 7 so the rotation below starts at channel 0.
    sel = 3'd7;
    tick();
    chk_out("fix_sel7", 1'b1, 3'd7);

    // Round-robin over a sparse valid mask, one beat per cycle.
    mode = 1'b1; in_valid = 8'b1010_0101;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out($sformatf("rr_beat%0d", i), 1'b1, 3'(rr_seq[i]));
    end

    // Backpressure: beat from channel 2 held for 3 cycles, nothing accepted.
    out_ready = 1'b0;
    #1;
    chk("bp_ready0", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("bp_hold%0d", i), 1'b1, 3'd2);
      chk($sformatf("bp_ready_hold%0d", i), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'h20);
    tick();
    chk_out("bp_next5", 1'b1, 3'd5);
    tick();
    chk_out("bp_next7", 1'b1, 3'd7);

    // No valid inputs: output empties, data and index keep their old values.
    in_valid = '0;
    #1;
    chk("idle_ready", 64'(in_ready), 64'd0);
    tick();
    chk_out("idle", 1'b0, 3'd7);

    // Mid-stream reset drops the held beat immediately.
    in_valid = 8'hFF;
    tick();
    chk_out("pre_rst0", 1'b1, 3'd0);
    tick();
    chk_out("pre_rst1", 1'b1, 3'd1);
    out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_data",  64'(out_data),  64'd0);
    chk("mrst_chan",  64'(out_chan),  64'd0);
    chk("mrst_ready", 64'(in_ready),  64'd0);
    tick();
    rst = 1'b1; out_ready = 1'b1;
    #1;
    chk("mrst_rr_ready", 64'(in_ready), 64'h01);
    tick();
    chk_out("mrst_rr_first", 1'b1, 3'd0);

`ifdef MUX_RR_ARB_LAST_EN
    // Channel 1 sends a 3-beat packet while channel 2 stays valid.
    in_valid = 8'b0000_0110; in_last = 8'b0000_0100;
    #1;
    chk("pkt_ready0", 64'(in_ready), 64'h02);
    tick();
    chk("pkt_b0_chan", 64'(out_chan), 64'd1);
    chk("pkt_b0_last", 64'(out_last), 64'd0);
    chk("pkt_lock_ready", 64'(in_ready), 64'h02);
    tick();
    chk("pkt_b1_chan", 64'(out_chan), 64'd1);
    chk("pkt_b1_last", 64'(out_last), 64'd0);
    in_last = 8'b0000_0110;
    tick();
    chk("pkt_b2_chan", 64'(out_chan), 64'd1);
    chk("pkt_b2_last", 64'(out_last), 64'd1);
    tick();
    chk("pkt_next_chan", 64'(out_chan), 64'd2);
`endif

    // Three channels: wrap at 2, then out-of-range sel gives no grant.
    d3_mode = 1'b1; d3_in_valid = 3'b111; d3_out_ready = 1'b1;
    #1;
    chk("c3_ready0", 64'(d3_in_ready), 64'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("c3_rr%0d_chan", i), 64'(d3_out_chan), 64'(d3_seq[i]));
      chk($sformatf("c3_rr%0d_data", i), 64'(d3_out_data), 64'(8'hA0 + d3_seq[i]));
    end
    d3_mode = 1'b0; d3_sel = 2'd3;
    #1;
    chk("c3_sel3_ready", 64'(d3_in_ready), 64'd0);
    tick();
    chk("c3_sel3_valid", 64'(d3_out_valid), 64'd0);
    chk("c3_sel3_chan",  64'(d3_out_chan),  64'd0);
    chk("c3_sel3_data",  64'(d3_out_data),  64'hA0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
